// File: rtl/bitonic_merge_pipe.sv
// Streaming bitonic merge network with a per-beat direction bit, a tag that
// travels with each key, configurable register density and a global stall.
module bitonic_merge_pipe #(
    parameter int KEY_BITS  = 8,
    parameter int TAG_BITS  = 4,
    parameter int DEPTH     = 3,
    parameter int REG_EVERY = 1,
    localparam int SIZE     = 1 << DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     in_desc,
    input  logic [SIZE*KEY_BITS-1:0] in_keys,
    input  logic [SIZE*TAG_BITS-1:0] in_tags,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_desc,
    output logic [SIZE*KEY_BITS-1:0] out_keys,
    output logic [SIZE*TAG_BITS-1:0] out_tags
);
    typedef logic [SIZE-1:0][KEY_BITS-1:0] kvec_t;
    typedef logic [SIZE-1:0][TAG_BITS-1:0] tvec_t;
    typedef struct packed {
        logic  desc;
        kvec_t keys;
        tvec_t tags;
    } beat_t;

    // stg[s] / vld_pipe[s] is what stage s sees; index DEPTH is the output.
    beat_t [DEPTH:0] stg;
    logic  [DEPTH:0] vld_pipe;
    logic            advance;

    // Global stall: everything moves together unless the head is blocked.
    assign advance   = !vld_pipe[DEPTH] || out_ready;
    assign in_ready  = advance;

    assign stg[0]      = {in_desc, in_keys, in_tags};
    assign vld_pipe[0] = in_valid;

    assign out_valid = vld_pipe[DEPTH];
    assign out_desc  = stg[DEPTH].desc;
    assign out_keys  = stg[DEPTH].keys;
    assign out_tags  = stg[DEPTH].tags;

    for (genvar s = 0; s < DEPTH; s++) begin : g_stg
        localparam int  D      = SIZE >> (s + 1);
        // Register closes every REG_EVERY-th stage and always the last one.
        localparam bit  IS_REG = (((s + 1) % REG_EVERY) == 0) || (s == DEPTH - 1);

        kvec_t cx_k;
        tvec_t cx_t;

        for (genvar p = 0; p < SIZE / 2; p++) begin : g_cx
            // p-th index with bit D clear, paired with its partner at +D
            localparam int I = (p / D) * 2 * D + (p % D);
            bitonic_cx #(
                .KEY_BITS (KEY_BITS),
                .TAG_BITS (TAG_BITS)
            ) u_cx (
                .desc (stg[s].desc),
                .ka   (stg[s].keys[I]),
                .kb   (stg[s].keys[I+D]),
                .ta   (stg[s].tags[I]),
                .tb   (stg[s].tags[I+D]),
                .kr_a (cx_k[I]),
                .kr_b (cx_k[I+D]),
                .tr_a (cx_t[I]),
                .tr_b (cx_t[I+D])
            );
        end

        if (IS_REG) begin : g_reg
            beat_t q;
            logic  v;
            // Pipeline register: clears on reset, loads on advance, else holds.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    v <= 1'b0;
                    q <= '0;
                end else if (advance) begin
                    v <= vld_pipe[s];
                    q <= {stg[s].desc, cx_k, cx_t};
                end
            end
            assign stg[s+1]      = q;
            assign vld_pipe[s+1] = v;
        end else begin : g_comb
            assign stg[s+1]      = {stg[s].desc, cx_k, cx_t};
            assign vld_pipe[s+1] = vld_pipe[s];
        end
    end
endmodule

// One compare-exchange: equal keys never swap so tag order on ties is fixed.
module bitonic_cx #(
    parameter int KEY_BITS = 8,
    parameter int TAG_BITS = 4
) (
    input  logic                desc,
    input  logic [KEY_BITS-1:0] ka,
    input  logic [KEY_BITS-1:0] kb,
    input  logic [TAG_BITS-1:0] ta,
    input  logic [TAG_BITS-1:0] tb,
    output logic [KEY_BITS-1:0] kr_a,
    output logic [KEY_BITS-1:0] kr_b,
    output logic [TAG_BITS-1:0] tr_a,
    output logic [TAG_BITS-1:0] tr_b
);
    logic swap;

    assign swap = desc ? (ka < kb) : (ka > kb);
    assign kr_a = swap ? kb : ka;
    assign kr_b = swap ? ka : kb;
    assign tr_a = swap ? tb : ta;
    assign tr_b = swap ? ta : tb;
endmodule

// File: tb/tb_bitonic_merge_pipe.sv
// Bench for bitonic_merge_pipe: four configurations driven from one stimulus
// stream, each checked against a per-configuration scoreboard.
module tb_bitonic_merge_pipe;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic              in_valid, vdesc, out_ready;
    logic [7:0][15:0]  vk;
    logic [7:0][7:0]   vt;
    bit                strict;
    int                cyc = 0;
    int                checks = 0;
    int                errors = 0;
    int                acc [4] = '{0, 0, 0, 0};
    int                lat [4] = '{3, 2, 1, 1};

    always @(posedge clk) cyc <= cyc + 1;

    // DUT A: KEY 8/TAG 4/DEPTH 3/RE 1, B: 16/8/3/2, C: 16/8/3/3, D: 16/8/1/1
    logic [63:0]  a_ki, a_ko;
    logic [31:0]  a_ti, a_to;
    logic [127:0] b_ki, b_ko, c_ki, c_ko;
    logic [63:0]  b_ti, b_to, c_ti, c_to;
    logic [31:0]  d_ki, d_ko;
    logic [15:0]  d_ti, d_to;
    logic [3:0]   ir, ov, od;
    logic [7:0][15:0] ok [4];
    logic [7:0][7:0]  ot [4];

    always_comb begin
        a_ki = '0;
        a_ti = '0;
        for (int e = 0; e < 8; e++) begin
            a_ki[e*8 +: 8] = vk[e][15:8];
            a_ti[e*4 +: 4] = vt[e][3:0];
        end
        b_ki = vk;
        b_ti = vt;
        c_ki = vk;
        c_ti = vt;
        d_ki = {vk[1], vk[0]};
        d_ti = {vt[1], vt[0]};
    end

    always_comb begin
        for (int u = 0; u < 4; u++) begin
            ok[u] = '0;
            ot[u] = '0;
        end
        for (int e = 0; e < 8; e++) begin
            ok[0][e] = {8'h00, a_ko[e*8 +: 8]};
            ot[0][e] = {4'h0, a_to[e*4 +: 4]};
        end
        ok[1] = b_ko;
        ot[1] = b_to;
        ok[2] = c_ko;
        ot[2] = c_to;
        ok[3][0] = d_ko[15:0];
        ok[3][1] = d_ko[31:16];
        ot[3][0] = d_to[7:0];
        ot[3][1] = d_to[15:8];
    end

    bitonic_merge_pipe #(.KEY_BITS(8), .TAG_BITS(4), .DEPTH(3), .REG_EVERY(1)) u_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[0]), .in_desc(vdesc),
        .in_keys(a_ki), .in_tags(a_ti), .out_valid(ov[0]), .out_ready(out_ready),
        .out_desc(od[0]), .out_keys(a_ko), .out_tags(a_to));
    bitonic_merge_pipe #(.KEY_BITS(16), .TAG_BITS(8), .DEPTH(3), .REG_EVERY(2)) u_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[1]), .in_desc(vdesc),
        .in_keys(b_ki), .in_tags(b_ti), .out_valid(ov[1]), .out_ready(out_ready),
        .out_desc(od[1]), .out_keys(b_ko), .out_tags(b_to));
    bitonic_merge_pipe #(.KEY_BITS(16), .TAG_BITS(8), .DEPTH(3), .REG_EVERY(3)) u_c (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[2]), .in_desc(vdesc),
        .in_keys(c_ki), .in_tags(c_ti), .out_valid(ov[2]), .out_ready(out_ready),
        .out_desc(od[2]), .out_keys(c_ko), .out_tags(c_to));
    bitonic_merge_pipe #(.KEY_BITS(16), .TAG_BITS(8), .DEPTH(1), .REG_EVERY(1)) u_d (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[3]), .in_desc(vdesc),
        .in_keys(d_ki), .in_tags(d_ti), .out_valid(ov[3]), .out_ready(out_ready),
        .out_desc(od[3]), .out_keys(d_ko), .out_tags(d_to));

    typedef struct {
        logic [7:0][15:0] k;
        logic [7:0][7:0]  t;
        logic             d;
        int               due;
        bit               strict;
    } exp_t;

    exp_t sb [4][$];
    exp_t h;
    bit   seen [4] = '{0, 0, 0, 0};

    // Reference: apply the merge rule literally, stage by stage on plain arrays.
    function automatic void merge_ref(input int n, input bit desc, inout int k[8], inout int t[8]);
        int tmp;
        for (int d = n / 2; d >= 1; d = d / 2)
            for (int i = 0; i < n; i++)
                if ((i & d) == 0 && (desc ? (k[i] < k[i+d]) : (k[i] > k[i+d]))) begin
                    tmp = k[i]; k[i] = k[i+d]; k[i+d] = tmp;
                    tmp = t[i]; t[i] = t[i+d]; t[i+d] = tmp;
                end
    endfunction

    function automatic exp_t build(input int u);
        int   k[8], t[8];
        int   n;
        exp_t r;
        n = (u == 3) ? 2 : 8;
        for (int e = 0; e < 8; e++) begin
            k[e] = (e >= n) ? 0 : (u == 0) ? int'(vk[e][15:8]) : int'(vk[e]);
            t[e] = (e >= n) ? 0 : (u == 0) ? int'(vt[e][3:0])  : int'(vt[e]);
        end
        merge_ref(n, vdesc, k, t);
        r.k = '0;
        r.t = '0;
        for (int j = 0; j < n; j++) begin
            r.k[j] = 16'(k[j]);
            r.t[j] = 8'(t[j]);
        end
        r.d      = vdesc;
        r.due    = cyc + lat[u];
        r.strict = strict;
        return r;
    endfunction

    function automatic bit arr_eq(input int a[8], input int b[8]);
        for (int i = 0; i < 8; i++) if (a[i] != b[i]) return 0;
        return 1;
    endfunction

    // Per-cycle checker: flow-control law, reset state, head-of-queue data, latency.
    always @(negedge clk) begin
        for (int u = 0; u < 4; u++) begin
            checks++;
            if (ir[u] !== (!ov[u] || out_ready)) begin
                errors++;
                $display("FAIL in_ready dut%0d cyc %0d: got %b want %b", u, cyc, ir[u], !ov[u] || out_ready);
            end
            if (rst) begin
                checks++;
                if (ov[u] !== 1'b0 || ok[u] !== '0 || ot[u] !== '0 || od[u] !== 1'b0) begin
                    errors++;
                    $display("FAIL reset_state dut%0d: got v=%b k=%h t=%h d=%b want all 0", u, ov[u], ok[u], ot[u], od[u]);
                end
                sb[u].delete();
                seen[u] = 0;
            end else begin
                if (ov[u]) begin
                    checks++;
                    if (sb[u].size() == 0) begin
                        errors++;
                        $display("FAIL spurious dut%0d cyc %0d: got out_valid=1 want 0 (k=%h)", u, cyc, ok[u]);
                    end else begin
                        h = sb[u][0];
                        if (ok[u] !== h.k || ot[u] !== h.t || od[u] !== h.d) begin
                            errors++;
                            $display("FAIL data dut%0d cyc %0d: got k=%h t=%h d=%b want k=%h t=%h d=%b",
                                     u, cyc, ok[u], ot[u], od[u], h.k, h.t, h.d);
                        end
                        if (!seen[u] && h.strict) begin
                            checks++;
                            if (cyc != h.due) begin
                                errors++;
                                $display("FAIL latency dut%0d: got cycle %0d want %0d", u, cyc, h.due);
                            end
                        end
                        seen[u] = 1;
                        if (out_ready) begin
                            void'(sb[u].pop_front());
                            seen[u] = 0;
                        end
                    end
                end
                if (in_valid && ir[u]) begin
                    sb[u].push_back(build(u));
                    acc[u]++;
                end
            end
        end
    end

    task automatic rand_vec();
        int  a[4], b[4];
        bit  dup;
        dup = ($urandom_range(0, 3) == 0);
        for (int i = 0; i < 4; i++) begin
            a[i] = dup ? int'($urandom_range(0, 2) * 256 + $urandom_range(0, 2)) : int'($urandom_range(0, 65535));
            b[i] = dup ? int'($urandom_range(0, 2) * 256 + $urandom_range(0, 2)) : int'($urandom_range(0, 65535));
        end
        a.sort();
        b.rsort();
        for (int i = 0; i < 4; i++) begin
            vk[i]   = 16'(a[i]);
            vk[i+4] = 16'(b[i]);
        end
        for (int i = 0; i < 8; i++) vt[i] = 8'($urandom_range(0, 255));
        vdesc = 1'($urandom_range(0, 1));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n = 0;
        in_valid  = 0;
        out_ready = 1;
        while ((sb[0].size() + sb[1].size() + sb[2].size() + sb[3].size()) != 0 && n < 200) begin
            step();
            n++;
        end
        step();
        checks++;
        if ((sb[0].size() + sb[1].size() + sb[2].size() + sb[3].size()) != 0) begin
            errors++;
            $display("FAIL drain: got pending %0d/%0d/%0d/%0d want 0", sb[0].size(), sb[1].size(), sb[2].size(), sb[3].size());
        end
    endtask

    initial begin
        int k[8], t[8], ek[8], et[8];
        int base[4];
        bit done;
        in_valid = 0; vdesc = 0; vk = '0; vt = '0; out_ready = 1; strict = 1;

        // Pin the reference model with hand-derived results.
        k = '{1, 4, 6, 9, 8, 5, 3, 0}; t = '{0, 1, 2, 3, 4, 5, 6, 7};
        merge_ref(8, 0, k, t);
        ek = '{0, 1, 3, 4, 5, 6, 8, 9}; et = '{7, 0, 6, 1, 5, 2, 4, 3};
        checks++;
        if (!arr_eq(k, ek) || !arr_eq(t, et)) begin
            errors++; $display("FAIL model_asc: got k=%p t=%p want k=%p t=%p", k, t, ek, et);
        end
        k = '{1, 4, 6, 9, 8, 5, 3, 0}; t = '{0, 1, 2, 3, 4, 5, 6, 7};
        merge_ref(8, 1, k, t);
        ek = '{9, 8, 6, 5, 4, 3, 1, 0}; et = '{3, 4, 2, 5, 1, 6, 0, 7};
        checks++;
        if (!arr_eq(k, ek) || !arr_eq(t, et)) begin
            errors++; $display("FAIL model_desc: got k=%p t=%p want k=%p t=%p", k, t, ek, et);
        end
        k = '{7, 7, 7, 7, 7, 7, 7, 7}; t = '{0, 1, 2, 3, 4, 5, 6, 7};
        merge_ref(8, 1, k, t);
        et = '{0, 1, 2, 3, 4, 5, 6, 7};
        checks++;
        if (!arr_eq(t, et)) begin
            errors++; $display("FAIL model_ties: got t=%p want %p", t, et);
        end

        repeat (2) @(posedge clk);
        #1 rst = 0;

        // Directed: ascending, descending, ties, alternating direction back-to-back.
        ek = '{1, 4, 6, 9, 8, 5, 3, 0};
        for (int i = 0; i < 8; i++) begin vk[i] = {8'(ek[i]), 8'h00}; vt[i] = 8'(i); end
        vdesc = 0; in_valid = 1; step();
        vdesc = 1; step();
        for (int i = 0; i < 8; i++) vk[i] = 16'h0700;
        vdesc = 0; step();
        vdesc = 1; step();
        for (int i = 0; i < 6; i++) begin rand_vec(); vdesc = 1'(i); step(); end
        drain();

        // Backpressure: full-rate stream with out_ready low on cycles 4..7.
        strict = 0;
        for (int c = 0; c < 12; c++) begin
            rand_vec();
            in_valid  = (c < 6);
            out_ready = !(c >= 4 && c <= 7);
            step();
        end
        drain();

        // Reset mid-flight, then accept on the first edge after release.
        strict = 1;
        rand_vec(); in_valid = 1; step();
        rand_vec(); step();
        in_valid = 0;
        rst = 1;
        #1;
        for (int u = 0; u < 4; u++) begin
            checks++;
            if (ov[u] !== 1'b0 || ok[u] !== '0 || ot[u] !== '0 || od[u] !== 1'b0 || ir[u] !== 1'b1) begin
                errors++;
                $display("FAIL async_reset dut%0d: got v=%b k=%h t=%h d=%b rdy=%b want 0/0/0/0/1",
                         u, ov[u], ok[u], ot[u], od[u], ir[u]);
            end
        end
        step();
        rand_vec(); in_valid = 1; rst = 0;
        step();
        drain();

        // Random sweep: at least 1000 accepted vectors per configuration.
        strict = 0;
        for (int u = 0; u < 4; u++) base[u] = acc[u];
        for (int c = 0; c < 20000; c++) begin
            done = 1;
            for (int u = 0; u < 4; u++) if (acc[u] < base[u] + 1000) done = 0;
            if (done) break;
            rand_vec();
            in_valid  = ($urandom_range(0, 9) < 8);
            out_ready = ($urandom_range(0, 9) < 7);
            step();
        end
        for (int u = 0; u < 4; u++) begin
            checks++;
            if (acc[u] < base[u] + 1000) begin
                errors++;
                $display("FAIL sweep_count dut%0d: got %0d want >= 1000", u, acc[u] - base[u]);
            end
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
